// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search sequencer: runs init/shuffle/decrypt per candidate key,
// screens decrypted bytes on the fly and stops on a plaintext hit, exhaustion, timeout or stop.
module rc4_key_search_ctrl #(
    parameter int unsigned         SEARCH_W  = 22,
    parameter logic [SEARCH_W-1:0] KEY_START = '0,
    parameter logic [SEARCH_W-1:0] KEY_END   = {SEARCH_W{1'b1}},
    parameter int unsigned         MSG_LEN   = 32,
    parameter int unsigned         TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                init_finish,
    input  logic                shuffle_finish,
    input  logic                decrypt_finish,
    input  logic                chk_wren,
    input  logic [7:0]          chk_data,
    output logic                init_start,
    output logic                shuffle_start,
    output logic                decrypt_start,
    output logic                pipe_rst,
    output logic [23:0]         secret_key,
    output logic [SEARCH_W-1:0] keys_tried,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLEAR   = 3'd1;
    localparam logic [2:0] INIT    = 3'd2;
    localparam logic [2:0] SHUFFLE = 3'd3;
    localparam logic [2:0] DECRYPT = 3'd4;
    localparam logic [2:0] NEXT    = 3'd5;
    localparam logic [2:0] FOUND   = 3'd6;
    localparam logic [2:0] FAIL    = 3'd7;

    function automatic logic is_busy(input logic [2:0] s);
        return (s >= CLEAR) && (s <= NEXT);
    endfunction

    logic [2:0]          state_q, state_d;
    logic [SEARCH_W-1:0] key_q, key_d;
    logic [SEARCH_W-1:0] tried_q, tried_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [TW-1:0]       phase_q, phase_d;
    logic                byte_ok, timed_out, stopped, clear_status, set_exh, set_to;
    logic [6:0]          cnt_total;

    always_comb begin
        byte_ok   = ((chk_data >= 8'h61) && (chk_data <= 8'h7A)) || (chk_data == 8'h20);
        cnt_total = {1'b0, cnt_q} + {6'd0, chk_wren & byte_ok};
        timed_out = (phase_q == TW'(TIMEOUT - 1));

        state_d      = state_q;
        key_d        = key_q;
        tried_d      = tried_q;
        cnt_d        = cnt_q;
        stopped      = 1'b0;
        clear_status = 1'b0;
        set_exh      = 1'b0;
        set_to       = 1'b0;

        if (is_busy(state_q) && stop) begin
            state_d = IDLE;
            stopped = 1'b1;
        end else begin
            case (state_q)
                IDLE, FOUND, FAIL: begin
                    if (start) begin
                        state_d      = CLEAR;
                        key_d        = KEY_START;
                        tried_d      = '0;
                        clear_status = 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_d   = '0;
                    state_d = INIT;
                end
                INIT: begin
                    // init_start is high only on the entry cycle, when a stale finish is ignored
                    if (init_finish && !init_start) begin
                        state_d = SHUFFLE;
                    end else if (timed_out) begin
                        state_d = FAIL;
                        set_to  = 1'b1;
                    end
                end
                SHUFFLE: begin
                    if (shuffle_finish) begin
                        state_d = DECRYPT;
                    end else if (timed_out) begin
                        state_d = FAIL;
                        set_to  = 1'b1;
                    end
                end
                DECRYPT: begin
                    if (chk_wren && !byte_ok) begin
                        state_d = NEXT;
                    end else begin
                        if (chk_wren) begin
                            cnt_d = cnt_q + 6'd1;
                        end
                        if (decrypt_finish) begin
                            state_d = (cnt_total == 7'(MSG_LEN)) ? FOUND : NEXT;
                        end else if (timed_out) begin
                            state_d = FAIL;
                            set_to  = 1'b1;
                        end
                    end
                end
                NEXT: begin
                    tried_d = tried_q + 1'b1;
                    if (key_q == KEY_END) begin
                        state_d = FAIL;
                        set_exh = 1'b1;
                    end else begin
                        key_d   = key_q + 1'b1;
                        state_d = CLEAR;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q) begin
            phase_d = '0;
        end else if (timed_out) begin
            phase_d = phase_q;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            key_q         <= KEY_START;
            tried_q       <= '0;
            cnt_q         <= '0;
            phase_q       <= '0;
            pipe_rst      <= 1'b0;
            init_start    <= 1'b0;
            shuffle_start <= 1'b0;
            decrypt_start <= 1'b0;
            busy          <= 1'b0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            tried_q       <= tried_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            pipe_rst      <= (state_d == CLEAR) || stopped;
            init_start    <= (state_d == INIT) && (state_q != INIT);
            shuffle_start <= (state_d == SHUFFLE) && (state_q != SHUFFLE);
            decrypt_start <= (state_d == DECRYPT) && (state_q != DECRYPT);
            busy          <= is_busy(state_d);
            found         <= (state_d == FOUND);
            if (clear_status) begin
                exhausted   <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (set_exh) exhausted   <= 1'b1;
                if (set_to)  timeout_err <= 1'b1;
            end
        end
    end

    assign secret_key = 24'(key_q);
    assign keys_tried = tried_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: three parameterisations driven by stub FSMs, checked every
// cycle against a phase-level behavioural model plus directed literal expectations.
module tb_rc4_key_search_ctrl;

    localparam int M_IDLE = 10, M_CLEAR = 11, M_INIT = 12, M_SHUF = 13;
    localparam int M_DEC = 14, M_NEXT = 15, M_FOUND = 16, M_FAIL = 17;

    function automatic logic [21:0] ks_of(input int i);
        return (i == 1) ? 22'h3FFFFF : 22'h000000;
    endfunction
    function automatic logic [21:0] ke_of(input int i);
        return (i >= 0) ? 22'h3FFFFF : 22'h3FFFFF;
    endfunction
    function automatic int to_of(input int i);
        return (i == 2) ? 16 : 4096;
    endfunction
    function automatic logic ok_byte(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction
    function automatic logic m_busy(input int ph);
        return ph == M_CLEAR || ph == M_INIT || ph == M_SHUF || ph == M_DEC || ph == M_NEXT;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [3], start_v [3], stop_v [3];
    logic        ifin [3], sfin [3], dfin [3], wren [3];
    logic [7:0]  wdata [3];
    logic        init_start [3], shuffle_start [3], decrypt_start [3], pipe_rst [3];
    logic        busy [3], found [3], exhausted [3], timeout_err [3];
    logic [23:0] secret_key [3];
    logic [21:0] keys_tried [3];

    // Stub knobs
    logic        bad_en [3], same_cyc [3], hang [3];
    logic [21:0] bad_key [3];
    logic [7:0]  bad_byte [3], good_byte [3];
    int          nbytes [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rc4_key_search_ctrl #(
            .SEARCH_W (22),
            .KEY_START(ks_of(g)),
            .KEY_END  (ke_of(g)),
            .MSG_LEN  (32),
            .TIMEOUT  (to_of(g))
        ) u_dut (
            .clk           (clk),
            .rst           (rst_v[g]),
            .start         (start_v[g]),
            .stop          (stop_v[g]),
            .init_finish   (ifin[g]),
            .shuffle_finish(sfin[g]),
            .decrypt_finish(dfin[g]),
            .chk_wren      (wren[g]),
            .chk_data      (wdata[g]),
            .init_start    (init_start[g]),
            .shuffle_start (shuffle_start[g]),
            .decrypt_start (decrypt_start[g]),
            .pipe_rst      (pipe_rst[g]),
            .secret_key    (secret_key[g]),
            .keys_tried    (keys_tried[g]),
            .busy          (busy[g]),
            .found         (found[g]),
            .exhausted     (exhausted[g]),
            .timeout_err   (timeout_err[g])
        );
    end

    // Stub FSMs: finish levels held until pipe_rst; decrypt writes nbytes bytes then finishes
    int          icnt [3], scnt [3], wleft [3];
    logic        dact [3], first [3];
    logic [21:0] dkey [3];
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i] || pipe_rst[i] === 1'b1) begin
                ifin[i] <= 1'b0; sfin[i] <= 1'b0; dfin[i] <= 1'b0; wren[i] <= 1'b0;
                wdata[i] <= 8'h00; icnt[i] <= 0; scnt[i] <= 0; wleft[i] <= 0;
                dact[i] <= 1'b0; first[i] <= 1'b0; dkey[i] <= '0;
            end else begin
                if (init_start[i]) icnt[i] <= 9;
                else if (icnt[i] == 1) begin ifin[i] <= 1'b1; icnt[i] <= 0; end
                else if (icnt[i] > 1) icnt[i] <= icnt[i] - 1;
                if (shuffle_start[i]) scnt[i] <= 9;
                else if (scnt[i] == 1) begin sfin[i] <= !hang[i]; scnt[i] <= 0; end
                else if (scnt[i] > 1) scnt[i] <= scnt[i] - 1;
                if (decrypt_start[i]) begin
                    dact[i] <= 1'b1; wleft[i] <= nbytes[i]; first[i] <= 1'b1;
                    dkey[i] <= secret_key[i][21:0]; wren[i] <= 1'b0;
                end else if (dact[i]) begin
                    if (wleft[i] > 0) begin
                        wren[i]  <= 1'b1;
                        wdata[i] <= (first[i] && bad_en[i] && dkey[i] == bad_key[i]) ?
                                    bad_byte[i] : good_byte[i];
                        first[i] <= 1'b0;
                        wleft[i] <= wleft[i] - 1;
                        if (wleft[i] == 1 && same_cyc[i]) begin
                            dfin[i] <= 1'b1; dact[i] <= 1'b0;
                        end
                    end else begin
                        wren[i] <= 1'b0; dfin[i] <= 1'b1; dact[i] <= 1'b0;
                    end
                end else begin
                    wren[i] <= 1'b0;
                end
            end
        end
    end

    // Behavioural model: phase, cycles spent in phase, key, tried count, status flags
    int          m_ph [3], m_age [3], m_cnt [3];
    logic [21:0] m_key [3], m_tried [3];
    logic        m_fnd [3], m_exh [3], m_to [3], m_sp [3];
    always @(posedge clk) begin : p_model
        int   nx;
        int   tot;
        logic sp;
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                m_ph[i] <= M_IDLE; m_age[i] <= 0; m_cnt[i] <= 0; m_key[i] <= ks_of(i);
                m_tried[i] <= '0; m_fnd[i] <= 1'b0; m_exh[i] <= 1'b0; m_to[i] <= 1'b0;
                m_sp[i] <= 1'b0;
            end else begin
                nx = m_ph[i];
                sp = 1'b0;
                if (m_busy(m_ph[i]) && stop_v[i]) begin
                    nx = M_IDLE;
                    sp = 1'b1;
                end else begin
                    case (m_ph[i])
                        M_IDLE, M_FOUND, M_FAIL: if (start_v[i]) begin
                            nx = M_CLEAR; m_key[i] <= ks_of(i); m_tried[i] <= '0;
                            m_fnd[i] <= 1'b0; m_exh[i] <= 1'b0; m_to[i] <= 1'b0;
                        end
                        M_CLEAR: begin m_cnt[i] <= 0; nx = M_INIT; end
                        M_INIT:
                            if (m_age[i] > 0 && ifin[i]) nx = M_SHUF;
                            else if (m_age[i] + 1 >= to_of(i)) begin nx = M_FAIL; m_to[i] <= 1'b1; end
                        M_SHUF:
                            if (sfin[i]) nx = M_DEC;
                            else if (m_age[i] + 1 >= to_of(i)) begin nx = M_FAIL; m_to[i] <= 1'b1; end
                        M_DEC:
                            if (wren[i] && !ok_byte(wdata[i])) nx = M_NEXT;
                            else begin
                                tot = m_cnt[i] + (wren[i] ? 1 : 0);
                                m_cnt[i] <= tot;
                                if (dfin[i]) nx = (tot == 32) ? M_FOUND : M_NEXT;
                                else if (m_age[i] + 1 >= to_of(i)) begin
                                    nx = M_FAIL; m_to[i] <= 1'b1;
                                end
                            end
                        M_NEXT: begin
                            m_tried[i] <= m_tried[i] + 22'd1;
                            if (m_key[i] == ke_of(i)) begin nx = M_FAIL; m_exh[i] <= 1'b1; end
                            else begin m_key[i] <= m_key[i] + 22'd1; nx = M_CLEAR; end
                        end
                        default: ;
                    endcase
                end
                if (nx == M_FOUND && m_ph[i] != M_FOUND) m_fnd[i] <= 1'b1;
                m_age[i] <= (nx != m_ph[i]) ? 0 : m_age[i] + 1;
                m_ph[i]  <= nx;
                m_sp[i]  <= sp;
            end
        end
    end

    int n_chk = 0, n_pass = 0, cyc = 0;
    int n_prst = 0, n_is = 0, n_ss = 0, n_ds = 0;
    int bad_cyc = -1, prst_cyc = -1, is_cyc = -1, sh_cyc = -1, to_cyc = -1;

    task automatic check_bit(input string name, input int i, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d: got %b, want %b", name, i, cyc, act, exp);
    endtask
    task automatic check_val(input string name, input int i, input logic [31:0] act,
                             input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d: got %0h, want %0h", name, i, cyc, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            check_bit("busy", i, busy[i], m_busy(m_ph[i]));
            check_bit("pipe_rst", i, pipe_rst[i], (m_ph[i] == M_CLEAR) || m_sp[i]);
            check_bit("init_start", i, init_start[i], m_ph[i] == M_INIT && m_age[i] == 0);
            check_bit("shuffle_start", i, shuffle_start[i], m_ph[i] == M_SHUF && m_age[i] == 0);
            check_bit("decrypt_start", i, decrypt_start[i], m_ph[i] == M_DEC && m_age[i] == 0);
            check_bit("found", i, found[i], m_fnd[i]);
            check_bit("exhausted", i, exhausted[i], m_exh[i]);
            check_bit("timeout_err", i, timeout_err[i], m_to[i]);
            check_val("secret_key", i, 32'(secret_key[i]), {10'd0, m_key[i]});
            check_val("keys_tried", i, 32'(keys_tried[i]), {10'd0, m_tried[i]});
        end
        n_prst += (pipe_rst[0] === 1'b1) ? 1 : 0;
        n_is   += (init_start[0] === 1'b1) ? 1 : 0;
        n_ss   += (shuffle_start[0] === 1'b1) ? 1 : 0;
        n_ds   += (decrypt_start[0] === 1'b1) ? 1 : 0;
        if (bad_cyc < 0 && wren[0] === 1'b1 && wdata[0] == 8'h41) bad_cyc = cyc;
        if (bad_cyc >= 0 && prst_cyc < 0 && cyc > bad_cyc && pipe_rst[0] === 1'b1) prst_cyc = cyc;
        if (bad_cyc >= 0 && is_cyc < 0 && cyc > bad_cyc && init_start[0] === 1'b1) is_cyc = cyc;
        if (sh_cyc < 0 && shuffle_start[2] === 1'b1) sh_cyc = cyc;
        if (to_cyc < 0 && timeout_err[2] === 1'b1) to_cyc = cyc;
    endtask

    task automatic launch(input int i);
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; stop_v[i] = 1'b0;
            bad_en[i] = 1'b0; same_cyc[i] = 1'b0; hang[i] = 1'b0; bad_key[i] = '0;
            bad_byte[i] = 8'h41; good_byte[i] = 8'h61; nbytes[i] = 32;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        tick();
        check_val("rst_key0", 0, 32'(secret_key[0]), 32'h000000);
        check_val("rst_key1", 1, 32'(secret_key[1]), 32'h3FFFFF);
        check_bit("rst_busy", 0, busy[0], 1'b0);

        // Key 0 decrypts to 32 x 'a'
        n_prst = 0; n_is = 0; n_ss = 0; n_ds = 0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check_bit("start_prst", 0, pipe_rst[0], 1'b1);
        check_bit("start_busy", 0, busy[0], 1'b1);
        tick();
        check_bit("start_init", 0, init_start[0], 1'b1);
        for (int c = 0; c < 400 && found[0] !== 1'b1; c++) tick();
        check_bit("s1_found", 0, found[0], 1'b1);
        check_bit("s1_busy", 0, busy[0], 1'b0);
        check_val("s1_key", 0, 32'(secret_key[0]), 32'h0);
        check_val("s1_tried", 0, 32'(keys_tried[0]), 32'd0);
        check_val("s1_n_prst", 0, n_prst, 1);
        check_val("s1_n_init", 0, n_is, 1);
        check_val("s1_n_shuf", 0, n_ss, 1);
        check_val("s1_n_dec", 0, n_ds, 1);

        // Key 0 opens with 'A', key 1 is all spaces
        bad_en[0] = 1'b1; bad_key[0] = 22'h0; bad_byte[0] = 8'h41; good_byte[0] = 8'h20;
        launch(0);
        for (int c = 0; c < 600 && found[0] !== 1'b1; c++) tick();
        check_bit("s2_found", 0, found[0], 1'b1);
        check_val("s2_key", 0, 32'(secret_key[0]), 32'h000001);
        check_val("s2_tried", 0, 32'(keys_tried[0]), 32'd1);
        check_val("s2_prst_lag", 0, prst_cyc - bad_cyc, 2);
        check_val("s2_init_lag", 0, is_cyc - bad_cyc, 3);

        // Single-key space, first byte just past 'z'
        bad_en[1] = 1'b1; bad_key[1] = 22'h3FFFFF; bad_byte[1] = 8'h7B;
        launch(1);
        for (int c = 0; c < 400 && exhausted[1] !== 1'b1; c++) tick();
        check_bit("s3_exh", 1, exhausted[1], 1'b1);
        check_bit("s3_busy", 1, busy[1], 1'b0);
        check_bit("s3_found", 1, found[1], 1'b0);
        check_val("s3_key", 1, 32'(secret_key[1]), 32'h3FFFFF);
        check_val("s3_tried", 1, 32'(keys_tried[1]), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        check_val("s3_key_hold", 1, 32'(secret_key[1]), 32'h3FFFFF);

        // Shuffle never finishes with a 16-cycle phase limit
        hang[2] = 1'b1;
        launch(2);
        for (int c = 0; c < 400 && timeout_err[2] !== 1'b1; c++) tick();
        check_bit("s4_to", 2, timeout_err[2], 1'b1);
        check_bit("s4_busy", 2, busy[2], 1'b0);
        check_val("s4_to_lag", 2, to_cyc - sh_cyc, 16);
        check_val("s4_key", 2, 32'(secret_key[2]), 32'h0);

        // stop together with a finish that would have been a full valid message
        bad_en[0] = 1'b0; good_byte[0] = 8'h61;
        launch(0);
        for (int c = 0; c < 400 && dfin[0] !== 1'b1; c++) tick();
        check_bit("s5_dfin", 0, dfin[0], 1'b1);
        stop_v[0] = 1'b1;
        n_prst = 0;
        tick();
        stop_v[0] = 1'b0;
        check_bit("s5_found", 0, found[0], 1'b0);
        check_bit("s5_busy", 0, busy[0], 1'b0);
        check_bit("s5_prst", 0, pipe_rst[0], 1'b1);
        for (int c = 0; c < 4; c++) tick();
        check_val("s5_n_prst", 0, n_prst, 1);
        check_val("s5_key", 0, 32'(secret_key[0]), 32'h0);

        // 31 valid bytes then finish: rejected; then rst mid-decrypt
        nbytes[0] = 31;
        launch(0);
        for (int c = 0; c < 400 && dfin[0] !== 1'b1; c++) tick();
        tick();
        check_bit("s6_next_busy", 0, busy[0], 1'b1);
        check_bit("s6_next_found", 0, found[0], 1'b0);
        tick();
        check_val("s6_tried", 0, 32'(keys_tried[0]), 32'd1);
        check_val("s6_key", 0, 32'(secret_key[0]), 32'h000001);
        check_bit("s6_prst", 0, pipe_rst[0], 1'b1);
        for (int c = 0; c < 200 && decrypt_start[0] !== 1'b1; c++) tick();
        for (int c = 0; c < 3; c++) tick();
        rst_v[0] = 1'b1;
        tick();
        check_val("s6_rst_key", 0, 32'(secret_key[0]), 32'h0);
        check_val("s6_rst_tried", 0, 32'(keys_tried[0]), 32'd0);
        check_bit("s6_rst_busy", 0, busy[0], 1'b0);
        check_bit("s6_rst_prst", 0, pipe_rst[0], 1'b0);
        rst_v[0] = 1'b0;
        tick();

        // 32nd byte written in the same cycle as finish still counts
        nbytes[0] = 32; same_cyc[0] = 1'b1;
        launch(0);
        for (int c = 0; c < 400 && found[0] !== 1'b1; c++) tick();
        check_bit("s7_found", 0, found[0], 1'b1);
        check_val("s7_key", 0, 32'(secret_key[0]), 32'h0);
        check_val("s7_tried", 0, 32'(keys_tried[0]), 32'd0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
